toy_bus_rr_arb2ch_tracker: RTL and testbench

Two-input round-robin arbiter for the toy_bus request channel, with per-input outstanding-transaction tracking and ack return routing. It sits in front of a shared target port such as the ITCM. It merges two ToyBusReq streams onto one output, holds each grant stable until the handshake completes, and blocks an input that has reached its outstanding limit. It steers ToyBusAck beats back to the originating input by tgt_id.

---
 rtl/toy_bus_pkg.sv | 34 +++
 rtl/toy_bus_outstd_cnt.sv | 37 +++
 rtl/toy_bus_rr_arb2ch_tracker.sv | 199 +++++++++++++++++++
 tb/tb_toy_bus_rr_arb2ch_tracker.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/toy_bus_pkg.sv
// toy_bus_pkg: shared field widths, request/ack payload structs and the
// arbiter state encoding for the toy_bus request-channel arbiter.
package toy_bus_pkg;

   localparam int ADDR_W = 32;
   localparam int STRB_W = 32;
   localparam int DATA_W = 256;
   localparam int ID_W   = 4;
   localparam int SB_W   = 32;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [STRB_W-1:0] strb;
      logic [DATA_W-1:0] data;
      logic              opcode;
      logic [ID_W-1:0]   src_id;
      logic [ID_W-1:0]   tgt_id;
      logic [SB_W-1:0]   sideband;
   } toy_bus_req_t;

   typedef struct packed {
      logic              opcode;
      logic [DATA_W-1:0] data;
      logic [SB_W-1:0]   sideband;
      logic [ID_W-1:0]   src_id;
      logic [ID_W-1:0]   tgt_id;
   } toy_bus_ack_t;

   typedef enum logic {
      ARB_IDLE   = 1'b0,
      ARB_LOCKED = 1'b1
   } arb_state_e;

endpackage

// File: rtl/toy_bus_outstd_cnt.sv
// toy_bus_outstd_cnt: per-input outstanding-transaction counter.
// Ports:
//   clk, rst_n  - clock, synchronous active-low reset
//   inc         - request handshake this cycle
//   dec         - ack handshake this cycle
//   count       - current outstanding count (0..MAX)
//   underflow   - one-cycle pulse, registered: dec seen while count was 0
module toy_bus_outstd_cnt
   import toy_bus_pkg::*;
#(
   parameter int MAX = 4,
   parameter int CW  = 3
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          inc,
   input  logic          dec,
   output logic [CW-1:0] count,
   output logic          underflow
);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count     <= '0;
         underflow <= 1'b0;
      end else begin
         underflow <= dec && (count == '0);
         if (inc && !dec) begin
            // eligibility upstream already prevents this; saturate anyway
            if (count < CW'(MAX)) count <= count + 1'b1;
         end else if (dec && !inc) begin
            if (count != '0) count <= count - 1'b1;
         end
      end
   end

endmodule

// File: rtl/toy_bus_rr_arb2ch_tracker.sv
// toy_bus_rr_arb2ch_tracker: two-input round-robin arbiter for the toy_bus
// request channel with per-input outstanding tracking and ack routing.
// Ports:
//   clk, rst_n              - clock, synchronous active-low reset
//   in0_req_*, in1_req_*    - upstream request channels (vld/rdy + payload)
//   out0_req_*              - merged request channel toward the target
//   out0_ack_*              - ack channel from the target
//   in0_ack_*, in1_ack_*    - routed ack channels (payload broadcast)
//   in0_outstd, in1_outstd  - outstanding request counts
//   err_unmapped_ack        - pulse: ack tgt_id matched neither input, dropped
//   err_ack_underflow       - pulse: ack taken for an input with count 0
//
// state      | meaning
// ARB_IDLE   | no grant held; pick eligible input, rr_ptr preferred
// ARB_LOCKED | grant held on input g until its request handshakes
module toy_bus_rr_arb2ch_tracker
   import toy_bus_pkg::*;
#(
   parameter logic [ID_W-1:0] IN0_ID     = 4'd0,
   parameter logic [ID_W-1:0] IN1_ID     = 4'd1,
   parameter int              MAX_OUTSTD = 4,
   localparam int             CW         = $clog2(MAX_OUTSTD + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in0_req_vld,
   output logic              in0_req_rdy,
   input  logic [ADDR_W-1:0] in0_req_addr,
   input  logic [STRB_W-1:0] in0_req_strb,
   input  logic [DATA_W-1:0] in0_req_data,
   input  logic              in0_req_opcode,
   input  logic [ID_W-1:0]   in0_req_src_id,
   input  logic [ID_W-1:0]   in0_req_tgt_id,
   input  logic [SB_W-1:0]   in0_req_sideband,
   input  logic              in1_req_vld,
   output logic              in1_req_rdy,
   input  logic [ADDR_W-1:0] in1_req_addr,
   input  logic [STRB_W-1:0] in1_req_strb,
   input  logic [DATA_W-1:0] in1_req_data,
   input  logic              in1_req_opcode,
   input  logic [ID_W-1:0]   in1_req_src_id,
   input  logic [ID_W-1:0]   in1_req_tgt_id,
   input  logic [SB_W-1:0]   in1_req_sideband,
   output logic              out0_req_vld,
   input  logic              out0_req_rdy,
   output logic [ADDR_W-1:0] out0_req_addr,
   output logic [STRB_W-1:0] out0_req_strb,
   output logic [DATA_W-1:0] out0_req_data,
   output logic              out0_req_opcode,
   output logic [ID_W-1:0]   out0_req_src_id,
   output logic [ID_W-1:0]   out0_req_tgt_id,
   output logic [SB_W-1:0]   out0_req_sideband,
   input  logic              out0_ack_vld,
   output logic              out0_ack_rdy,
   input  logic              out0_ack_opcode,
   input  logic [DATA_W-1:0] out0_ack_data,
   input  logic [SB_W-1:0]   out0_ack_sideband,
   input  logic [ID_W-1:0]   out0_ack_src_id,
   input  logic [ID_W-1:0]   out0_ack_tgt_id,
   output logic              in0_ack_vld,
   input  logic              in0_ack_rdy,
   output logic              in0_ack_opcode,
   output logic [DATA_W-1:0] in0_ack_data,
   output logic [SB_W-1:0]   in0_ack_sideband,
   output logic [ID_W-1:0]   in0_ack_src_id,
   output logic [ID_W-1:0]   in0_ack_tgt_id,
   output logic              in1_ack_vld,
   input  logic              in1_ack_rdy,
   output logic              in1_ack_opcode,
   output logic [DATA_W-1:0] in1_ack_data,
   output logic [SB_W-1:0]   in1_ack_sideband,
   output logic [ID_W-1:0]   in1_ack_src_id,
   output logic [ID_W-1:0]   in1_ack_tgt_id,
   output logic [CW-1:0]     in0_outstd,
   output logic [CW-1:0]     in1_outstd,
   output logic              err_unmapped_ack,
   output logic              err_ack_underflow
);

   if (IN0_ID == IN1_ID) begin : g_bad_ids
      $error("toy_bus_rr_arb2ch_tracker: IN0_ID and IN1_ID must differ");
   end

   arb_state_e   state;
   logic         rr_ptr;
   logic         g;
   logic         elig0, elig1, any_elig;
   logic         sel;
   logic         req_hs0, req_hs1, ack_hs0, ack_hs1;
   logic         hit0, hit1;
   logic         uf0, uf1;
   toy_bus_req_t req0, req1, req_out;
   toy_bus_ack_t ack_in;

   assign req0 = '{in0_req_addr, in0_req_strb, in0_req_data, in0_req_opcode,
                   in0_req_src_id, in0_req_tgt_id, in0_req_sideband};
   assign req1 = '{in1_req_addr, in1_req_strb, in1_req_data, in1_req_opcode,
                   in1_req_src_id, in1_req_tgt_id, in1_req_sideband};

   assign elig0    = in0_req_vld && (in0_outstd < CW'(MAX_OUTSTD));
   assign elig1    = in1_req_vld && (in1_outstd < CW'(MAX_OUTSTD));
   assign any_elig = elig0 || elig1;

   // In IDLE the preferred input wins if eligible, otherwise the other one;
   // out0_req_vld is gated by any_elig so a blocked-only choice never shows.
   always_comb begin
      sel = 1'b0;
      if (state == ARB_LOCKED) sel = g;
      else if (rr_ptr)         sel = elig1 ? 1'b1 : 1'b0;
      else                     sel = elig0 ? 1'b0 : 1'b1;
   end

   assign req_out      = sel ? req1 : req0;
   assign out0_req_vld = (state == ARB_LOCKED) ? (g ? in1_req_vld : in0_req_vld) : any_elig;
   assign in0_req_rdy  = out0_req_rdy && !sel && ((state == ARB_LOCKED) || any_elig);
   assign in1_req_rdy  = out0_req_rdy &&  sel && ((state == ARB_LOCKED) || any_elig);

   assign {out0_req_addr, out0_req_strb, out0_req_data, out0_req_opcode,
           out0_req_src_id, out0_req_tgt_id, out0_req_sideband} = req_out;

   assign req_hs0 = in0_req_vld && in0_req_rdy;
   assign req_hs1 = in1_req_vld && in1_req_rdy;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= ARB_IDLE;
         rr_ptr <= 1'b0;
         g      <= 1'b0;
      end else begin
         case (state)
            ARB_IDLE: begin
               if (out0_req_vld) begin
                  if (out0_req_rdy) begin
                     rr_ptr <= ~sel;
                  end else begin
                     state <= ARB_LOCKED;
                     g     <= sel;
                  end
               end
            end
            ARB_LOCKED: begin
               if (out0_req_vld && out0_req_rdy) begin
                  state  <= ARB_IDLE;
                  rr_ptr <= ~g;
               end
            end
            default: state <= ARB_IDLE;
         endcase
      end
   end

   assert property (@(posedge clk) disable iff (!rst_n)
      (state == ARB_LOCKED) |-> (g ? in1_req_vld : in0_req_vld))
      else $error("toy_bus_rr_arb2ch_tracker: request vld dropped while locked");

   // Ack router: unmapped beats are swallowed so the target never stalls.
   assign hit0 = (out0_ack_tgt_id == IN0_ID);
   assign hit1 = (out0_ack_tgt_id == IN1_ID);

   assign in0_ack_vld  = out0_ack_vld && hit0;
   assign in1_ack_vld  = out0_ack_vld && hit1;
   assign out0_ack_rdy = hit0 ? in0_ack_rdy : (hit1 ? in1_ack_rdy : 1'b1);

   assign ack_in = '{out0_ack_opcode, out0_ack_data, out0_ack_sideband,
                     out0_ack_src_id, out0_ack_tgt_id};
   assign {in0_ack_opcode, in0_ack_data, in0_ack_sideband,
           in0_ack_src_id, in0_ack_tgt_id} = ack_in;
   assign {in1_ack_opcode, in1_ack_data, in1_ack_sideband,
           in1_ack_src_id, in1_ack_tgt_id} = ack_in;

   assign ack_hs0 = in0_ack_vld && in0_ack_rdy;
   assign ack_hs1 = in1_ack_vld && in1_ack_rdy;

   always_ff @(posedge clk) begin
      if (!rst_n) err_unmapped_ack <= 1'b0;
      else        err_unmapped_ack <= out0_ack_vld && !hit0 && !hit1;
   end

   toy_bus_outstd_cnt #(.MAX(MAX_OUTSTD), .CW(CW)) u_cnt0 (
      .clk       (clk),
      .rst_n     (rst_n),
      .inc       (req_hs0),
      .dec       (ack_hs0),
      .count     (in0_outstd),
      .underflow (uf0)
   );

   toy_bus_outstd_cnt #(.MAX(MAX_OUTSTD), .CW(CW)) u_cnt1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .inc       (req_hs1),
      .dec       (ack_hs1),
      .count     (in1_outstd),
      .underflow (uf1)
   );

   assign err_ack_underflow = uf0 || uf1;

endmodule

// File: tb/tb_toy_bus_rr_arb2ch_tracker.sv
// Directed testbench for toy_bus_rr_arb2ch_tracker (IN0_ID=0, IN1_ID=1, MAX_OUTSTD=4).
module tb_toy_bus_rr_arb2ch_tracker;
   import toy_bus_pkg::*;

   localparam int CW = 3;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic              in0_req_vld, in0_req_rdy, in1_req_vld, in1_req_rdy;
   logic [ADDR_W-1:0] in0_req_addr, in1_req_addr, out0_req_addr;
   logic [STRB_W-1:0] in0_req_strb, in1_req_strb, out0_req_strb;
   logic [DATA_W-1:0] in0_req_data, in1_req_data, out0_req_data;
   logic              in0_req_opcode, in1_req_opcode, out0_req_opcode;
   logic [ID_W-1:0]   in0_req_src_id, in1_req_src_id, out0_req_src_id;
   logic [ID_W-1:0]   in0_req_tgt_id, in1_req_tgt_id, out0_req_tgt_id;
   logic [SB_W-1:0]   in0_req_sideband, in1_req_sideband, out0_req_sideband;
   logic              out0_req_vld, out0_req_rdy;
   logic              out0_ack_vld, out0_ack_rdy, out0_ack_opcode;
   logic [DATA_W-1:0] out0_ack_data, in0_ack_data, in1_ack_data;
   logic [SB_W-1:0]   out0_ack_sideband, in0_ack_sideband, in1_ack_sideband;
   logic [ID_W-1:0]   out0_ack_src_id, in0_ack_src_id, in1_ack_src_id;
   logic [ID_W-1:0]   out0_ack_tgt_id, in0_ack_tgt_id, in1_ack_tgt_id;
   logic              in0_ack_vld, in0_ack_rdy, in0_ack_opcode;
   logic              in1_ack_vld, in1_ack_rdy, in1_ack_opcode;
   logic [CW-1:0]     in0_outstd, in1_outstd;
   logic              err_unmapped_ack, err_ack_underflow;

   toy_bus_rr_arb2ch_tracker #(.IN0_ID(4'd0), .IN1_ID(4'd1), .MAX_OUTSTD(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .in0_req_vld(in0_req_vld), .in0_req_rdy(in0_req_rdy),
      .in0_req_addr(in0_req_addr), .in0_req_strb(in0_req_strb), .in0_req_data(in0_req_data),
      .in0_req_opcode(in0_req_opcode), .in0_req_src_id(in0_req_src_id),
      .in0_req_tgt_id(in0_req_tgt_id), .in0_req_sideband(in0_req_sideband),
      .in1_req_vld(in1_req_vld), .in1_req_rdy(in1_req_rdy),
      .in1_req_addr(in1_req_addr), .in1_req_strb(in1_req_strb), .in1_req_data(in1_req_data),
      .in1_req_opcode(in1_req_opcode), .in1_req_src_id(in1_req_src_id),
      .in1_req_tgt_id(in1_req_tgt_id), .in1_req_sideband(in1_req_sideband),
      .out0_req_vld(out0_req_vld), .out0_req_rdy(out0_req_rdy),
      .out0_req_addr(out0_req_addr), .out0_req_strb(out0_req_strb), .out0_req_data(out0_req_data),
      .out0_req_opcode(out0_req_opcode), .out0_req_src_id(out0_req_src_id),
      .out0_req_tgt_id(out0_req_tgt_id), .out0_req_sideband(out0_req_sideband),
      .out0_ack_vld(out0_ack_vld), .out0_ack_rdy(out0_ack_rdy),
      .out0_ack_opcode(out0_ack_opcode), .out0_ack_data(out0_ack_data),
      .out0_ack_sideband(out0_ack_sideband), .out0_ack_src_id(out0_ack_src_id),
      .out0_ack_tgt_id(out0_ack_tgt_id),
      .in0_ack_vld(in0_ack_vld), .in0_ack_rdy(in0_ack_rdy),
      .in0_ack_opcode(in0_ack_opcode), .in0_ack_data(in0_ack_data),
      .in0_ack_sideband(in0_ack_sideband), .in0_ack_src_id(in0_ack_src_id),
      .in0_ack_tgt_id(in0_ack_tgt_id),
      .in1_ack_vld(in1_ack_vld), .in1_ack_rdy(in1_ack_rdy),
      .in1_ack_opcode(in1_ack_opcode), .in1_ack_data(in1_ack_data),
      .in1_ack_sideband(in1_ack_sideband), .in1_ack_src_id(in1_ack_src_id),
      .in1_ack_tgt_id(in1_ack_tgt_id),
      .in0_outstd(in0_outstd), .in1_outstd(in1_outstd),
      .err_unmapped_ack(err_unmapped_ack), .err_ack_underflow(err_ack_underflow)
   );

   int n_chk = 0;
   int n_err = 0;

   task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #3;
   endtask

   task automatic set_req(input logic v0, input logic v1, input logic rdy);
      in0_req_vld  = v0;
      in1_req_vld  = v1;
      out0_req_rdy = rdy;
   endtask

   task automatic set_ack(input logic v, input logic [3:0] tgt);
      out0_ack_vld    = v;
      out0_ack_tgt_id = tgt;
   endtask

   initial begin
      rst_n = 1'b0;
      set_req(1'b0, 1'b0, 1'b0);
      set_ack(1'b0, 4'd0);
      in0_ack_rdy = 1'b1;
      in1_ack_rdy = 1'b1;
      in0_req_addr = 32'hA000_0000; in0_req_strb = '1; in0_req_data = 256'hA0;
      in0_req_opcode = 1'b0; in0_req_src_id = 4'd0; in0_req_tgt_id = 4'd8;
      in0_req_sideband = 32'h0000_00A0;
      in1_req_addr = 32'hB000_0000; in1_req_strb = '1; in1_req_data = 256'hB1;
      in1_req_opcode = 1'b1; in1_req_src_id = 4'd1; in1_req_tgt_id = 4'd8;
      in1_req_sideband = 32'h0000_00B1;
      out0_ack_opcode = 1'b0; out0_ack_data = 256'h5A5A; out0_ack_sideband = 32'h77;
      out0_ack_src_id = 4'd8;

      // reset state
      step(); step(); settle();
      check_eq("rst_out_vld", out0_req_vld, 1'b0);
      check_eq("rst_in0_rdy", in0_req_rdy, 1'b0);
      check_eq("rst_in1_rdy", in1_req_rdy, 1'b0);
      check_eq("rst_cnt0", in0_outstd, 3'd0);
      check_eq("rst_cnt1", in1_outstd, 3'd0);
      check_eq("rst_err_unm", err_unmapped_ack, 1'b0);
      check_eq("rst_err_uf", err_ack_underflow, 1'b0);
      check_eq("rst_ack_rdy", out0_ack_rdy, 1'b1);
      rst_n = 1'b1;
      step();

      // round-robin: both valid, ack returned for the previous grant
      for (int k = 0; k < 6; k++) begin
         set_req(1'b1, 1'b1, 1'b1);
         if (k == 0) set_ack(1'b0, 4'd0);
         else        set_ack(1'b1, 4'((k - 1) % 2));
         settle();
         check_eq($sformatf("rr_grant%0d", k), out0_req_src_id, 4'(k % 2));
         check_eq($sformatf("rr_win_rdy%0d", k), (k % 2) ? in1_req_rdy : in0_req_rdy, 1'b1);
         check_eq($sformatf("rr_lose_rdy%0d", k), (k % 2) ? in0_req_rdy : in1_req_rdy, 1'b0);
         step();
      end
      set_req(1'b0, 1'b0, 1'b1);
      set_ack(1'b1, 4'd1);
      step();
      set_ack(1'b0, 4'd0);
      settle();
      check_eq("rr_cnt0", in0_outstd, 3'd0);
      check_eq("rr_cnt1", in1_outstd, 3'd0);

      // grant stability: move rr_ptr to in1, then stall with both valid
      set_req(1'b1, 1'b0, 1'b1);
      step();
      settle();
      check_eq("gs_cnt0", in0_outstd, 3'd1);
      for (int j = 0; j < 3; j++) begin
         set_req(1'b1, 1'b1, 1'b0);
         settle();
         check_eq($sformatf("gs_src%0d", j), out0_req_src_id, 4'd1);
         check_eq($sformatf("gs_addr%0d", j), out0_req_addr, 32'hB000_0000);
         check_eq($sformatf("gs_in0_rdy%0d", j), in0_req_rdy, 1'b0);
         step();
      end
      set_req(1'b1, 1'b1, 1'b1);
      settle();
      check_eq("gs_hs_src", out0_req_src_id, 4'd1);
      check_eq("gs_hs_in1_rdy", in1_req_rdy, 1'b1);
      check_eq("gs_hs_in0_rdy", in0_req_rdy, 1'b0);
      step();
      settle();
      check_eq("gs_next_src", out0_req_src_id, 4'd0);
      check_eq("gs_next_in0_rdy", in0_req_rdy, 1'b1);
      step();
      set_req(1'b0, 1'b0, 1'b0);
      settle();
      check_eq("gs_cnt0_end", in0_outstd, 3'd2);
      check_eq("gs_cnt1_end", in1_outstd, 3'd1);

      // simultaneous request and ack on in0 at count 2
      set_req(1'b1, 1'b0, 1'b1);
      set_ack(1'b1, 4'd0);
      settle();
      check_eq("sim_req_rdy", in0_req_rdy, 1'b1);
      check_eq("sim_ack_vld", in0_ack_vld, 1'b1);
      step();
      set_req(1'b0, 1'b0, 1'b0);
      set_ack(1'b0, 4'd0);
      settle();
      check_eq("sim_cnt0", in0_outstd, 3'd2);
      set_ack(1'b1, 4'd1);
      step();
      set_ack(1'b0, 4'd0);
      settle();
      check_eq("sim_cnt1", in1_outstd, 3'd0);
      check_eq("sim_no_uf", err_ack_underflow, 1'b0);

      // outstanding limit on in0
      for (int i = 0; i < 2; i++) begin
         set_req(1'b1, 1'b0, 1'b1);
         step();
      end
      set_req(1'b0, 1'b0, 1'b0);
      settle();
      check_eq("lim_cnt0_full", in0_outstd, 3'd4);
      set_req(1'b1, 1'b1, 1'b1);
      settle();
      check_eq("lim_in0_blocked", in0_req_rdy, 1'b0);
      check_eq("lim_in1_src", out0_req_src_id, 4'd1);
      check_eq("lim_in1_rdy", in1_req_rdy, 1'b1);
      step();
      set_req(1'b1, 1'b0, 1'b1);
      set_ack(1'b1, 4'd0);
      settle();
      check_eq("lim_only_blocked_vld", out0_req_vld, 1'b0);
      check_eq("lim_only_blocked_rdy", in0_req_rdy, 1'b0);
      step();
      set_ack(1'b0, 4'd0);
      settle();
      check_eq("lim_cnt0_freed", in0_outstd, 3'd3);
      check_eq("lim_in0_eligible", in0_req_rdy, 1'b1);
      check_eq("lim_in0_vld", out0_req_vld, 1'b1);
      step();
      set_req(1'b0, 1'b0, 1'b0);
      settle();
      check_eq("lim_cnt0_refill", in0_outstd, 3'd4);
      check_eq("lim_cnt1", in1_outstd, 3'd1);

      // unmapped ack is dropped even with both inputs stalling acks
      in0_ack_rdy = 1'b0;
      in1_ack_rdy = 1'b0;
      set_ack(1'b1, 4'hF);
      settle();
      check_eq("unm_ack_rdy", out0_ack_rdy, 1'b1);
      check_eq("unm_in0_vld", in0_ack_vld, 1'b0);
      check_eq("unm_in1_vld", in1_ack_vld, 1'b0);
      step();
      set_ack(1'b0, 4'd0);
      in0_ack_rdy = 1'b1;
      in1_ack_rdy = 1'b1;
      settle();
      check_eq("unm_pulse", err_unmapped_ack, 1'b1);
      step();
      check_eq("unm_pulse_end", err_unmapped_ack, 1'b0);

      // underflow on in1
      set_ack(1'b1, 4'd1);
      step();
      set_ack(1'b0, 4'd0);
      settle();
      check_eq("uf_cnt1_zero", in1_outstd, 3'd0);
      check_eq("uf_not_yet", err_ack_underflow, 1'b0);
      set_ack(1'b1, 4'd1);
      settle();
      check_eq("uf_fwd_vld", in1_ack_vld, 1'b1);
      check_eq("uf_fwd_data", in1_ack_data, 256'h5A5A);
      step();
      set_ack(1'b0, 4'd0);
      settle();
      check_eq("uf_pulse", err_ack_underflow, 1'b1);
      check_eq("uf_cnt1_stays", in1_outstd, 3'd0);
      step();
      check_eq("uf_pulse_end", err_ack_underflow, 1'b0);

      // reset while locked on in1 (rr_ptr currently favours in1)
      set_req(1'b0, 1'b1, 1'b0);
      settle();
      check_eq("rl_lock_src", out0_req_src_id, 4'd1);
      step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      settle();
      check_eq("rl_cnt0", in0_outstd, 3'd0);
      check_eq("rl_cnt1", in1_outstd, 3'd0);
      set_req(1'b1, 1'b1, 1'b1);
      settle();
      check_eq("rl_in0_wins", out0_req_src_id, 4'd0);
      check_eq("rl_in0_rdy", in0_req_rdy, 1'b1);
      check_eq("rl_in1_rdy", in1_req_rdy, 1'b0);
      step();
      set_req(1'b0, 1'b0, 1'b0);
      step();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
